flopenr: RTL and testbench
==========================

Name: flopenr

Overview:
- Resettable, enabled D flip-flop register; basic state element of the MIPS datapath (PC, IR, and similar enabled registers).
- Captures d on the rising clock edge when en is high, otherwise holds.
- Synchronous active-low reset forces q to a fixed reset value.
- Width is parameterized; the default instance is 1 bit.

Parameters:
- WIDTH, 1, data width of d and q in bits; legal range 1..64.
- RST_VAL, 0 (WIDTH bits), value loaded into q by reset.

Ports:
- clk  input  1  clock; all state changes on the rising edge only.
- rst  input  1  reset, synchronous, active-low; clock clk.
- en  input  1  load enable, active-high.
- d  input  WIDTH  data to capture.
- q  output  WIDTH  registered data; driven directly from the flop, with no combinational path from any input.

Behaviour:
- All evaluation occurs on the posedge of clk; there is no asynchronous path.
- Priority at each posedge, highest first:
  - rst == 0 -> q <= RST_VAL, regardless of en and d.
  - rst == 1, en == 1 -> q <= d.
  - rst == 1, en == 0 -> q holds its previous value.
- Latency: q reflects the captured d one clock edge after capture (visible after the posedge), and is stable for the whole following cycle.
- Reset timing:
  - rst low between edges has no effect until the next posedge.
  - Deasserting rst mid-cycle has no effect until the next posedge.
  - A reset pulse that does not span a posedge is ignored.
- Simultaneous rst == 0 and en == 1: reset wins, q = RST_VAL.
- Reset value: q = RST_VAL after any posedge sampled with rst == 0.
- Power-up: q is undefined (X in simulation) until the first posedge with rst == 0, or with rst == 1 and en == 1. No initial value is implied.
- X handling in simulation:
  - en == X with rst == 1 -> q becomes X, unless d equals the current q (in which case q keeps its value).
  - rst == X -> q becomes X.
- en and d changing between edges does not affect q; only values sampled at the posedge matter.
- Data bits are independent; no arithmetic is performed.
- Synthesizable as WIDTH flops with a sync-reset mux and a load-enable mux; no latches.

Test Plan:
- Reset:
  - rst=0, en=1, d=1, posedge -> q=0 (RST_VAL).
  - Hold rst=0 for 3 edges with d toggling -> q stays 0.
- Load:
  - rst=1, en=1, d=1, posedge -> q=1.
  - Next edge d=0, en=1 -> q=0.
  - Value is sampled at the edge: d changed after the edge does not alter q until the next edge.
- Hold:
  - q=1, then rst=1, en=0, d=0 for 2 edges -> q stays 1.
  - en=1 on the next edge -> q=0.
- Sync-reset timing:
  - q=1, rst pulsed low for 5 ns between edges with no posedge inside the pulse -> q stays 1.
  - rst low across a posedge -> q=0 at that edge, not before.
- Priority:
  - rst=0 and en=1 with d=1 at the same edge -> q=0.
  - Release rst with en=1, d=1 -> q=1 on the following edge.
- Parameterized instance, WIDTH=8, RST_VAL=8'hA5:
  - Reset -> q=8'hA5.
  - en=1, d=8'h3C -> q=8'h3C.
  - en=0, d=8'hFF -> q stays 8'h3C.

Source files
------------

// File: rtl/flopenr.sv
// Enabled register with synchronous active-low reset: the basic state element
// for datapath registers such as PC and IR.
module flopenr #(
    parameter int unsigned    WIDTH   = 1,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] q_d;
    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] rst_poison;

    // Ternary muxes (rather than if/else) so an unknown en merges d with q
    // bitwise, and rst_poison turns an unknown rst into an unknown q.
    always_comb begin
        load_val   = en ? d : q_q;
        rst_poison = {WIDTH{rst ^ rst}};
        q_d        = (rst ? load_val : RST_VAL) ^ rst_poison;
    end

    always_ff @(posedge clk) begin
        q_q <= q_d;
    end

    assign q = q_q;

endmodule

// File: tb/tb_flopenr.sv
// Self-checking bench for flopenr: directed steps plus a randomized run,
// checked against a cycle-level model of the register rules.
module tb_flopenr;

    logic       clk;
    logic       rst;
    logic       en;
    logic       d1;
    logic [7:0] d8;
    logic       q1;
    logic [7:0] q8;

    logic       exp1;
    logic [7:0] exp8;

    int n_checks;
    int n_fails;

    flopenr u_dut1 (
        .clk (clk),
        .rst (rst),
        .en  (en),
        .d   (d1),
        .q   (q1)
    );

    flopenr #(.WIDTH(8), .RST_VAL(8'hA5)) u_dut8 (
        .clk (clk),
        .rst (rst),
        .en  (en),
        .d   (d8),
        .q   (q8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive inputs well away from the edge, take one posedge, update the
    // reference model from the values present at that edge, then step off it.
    task automatic step(input logic r, input logic e, input logic v1, input logic [7:0] v8);
        rst = r;
        en  = e;
        d1  = v1;
        d8  = v8;
        @(posedge clk);
        if (!r) begin
            exp1 = 1'b0;
            exp8 = 8'hA5;
        end else if (e) begin
            exp1 = v1;
            exp8 = v8;
        end
        #1;
    endtask

    task automatic check(input string tag);
        n_checks++;
        assert (q1 === exp1) else begin
            n_fails++;
            $error("FAIL %s w1: observed %b expected %b", tag, q1, exp1);
        end
        n_checks++;
        assert (q8 === exp8) else begin
            n_fails++;
            $error("FAIL %s w8: observed %h expected %h", tag, q8, exp8);
        end
    endtask

    initial begin
        n_checks = 0;
        n_fails  = 0;
        exp1 = 1'bx;
        exp8 = 8'hxx;
        rst = 1'b1; en = 1'b0; d1 = 1'b0; d8 = 8'h00;
        #2;

        // Reset wins over enable
        step(1'b0, 1'b1, 1'b1, 8'hFF); check("reset_en");
        step(1'b0, 1'b1, 1'b0, 8'h12); check("reset_hold0");
        step(1'b0, 1'b1, 1'b1, 8'h34); check("reset_hold1");
        step(1'b0, 1'b0, 1'b0, 8'h56); check("reset_hold2");

        // Load and sample-at-edge behaviour
        step(1'b1, 1'b1, 1'b1, 8'h3C); check("load_1");
        d1 = 1'b0; d8 = 8'hC3;
        #3; check("late_d_ignored");
        step(1'b1, 1'b1, 1'b0, 8'h3C); check("load_0");
        step(1'b1, 1'b1, 1'b1, 8'h3C); check("load_1b");

        // Hold with en low
        step(1'b1, 1'b0, 1'b0, 8'hFF); check("hold_a");
        step(1'b1, 1'b0, 1'b0, 8'hFF); check("hold_b");
        step(1'b1, 1'b1, 1'b0, 8'h81); check("hold_then_load");
        step(1'b1, 1'b1, 1'b1, 8'h7E); check("reload_1");

        // A reset pulse that misses the edge is ignored
        rst = 1'b0; #5; rst = 1'b1;
        #1; check("glitch_between_edges");
        step(1'b1, 1'b0, 1'b0, 8'h00); check("glitch_after_edge");
        rst = 1'b0;
        #1; check("rst_low_before_edge");
        step(1'b0, 1'b0, 1'b1, 8'h11); check("rst_across_edge");

        // Simultaneous reset and enable, then release
        step(1'b1, 1'b1, 1'b1, 8'h99); check("pre_priority");
        step(1'b0, 1'b1, 1'b1, 8'h99); check("priority_reset");
        step(1'b1, 1'b1, 1'b1, 8'h99); check("release_load");

        // Randomized run against the model
        for (int i = 0; i < 300; i++) begin
            step(($urandom_range(7) != 0), $urandom_range(1), $urandom_range(1),
                 8'($urandom_range(255)));
            check("random");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
